clk_gen_multi: RTL and testbench
================================

Name: clk_gen_multi

Overview:
Multi-channel programmable clock/tick generator. Successor to the single-channel divider in the controller.
- NUM_CH independent channels, each with programmable period, duty and mode (off / free-run / counted burst).
- Outputs are registered divided-clock levels plus one-cycle tick enables; no gated clocks.
- Sits between the controller's command decoder and the processor-under-test clock domain logic.

Parameters:
NUM_CH, 2, number of independent channels (1..16)
COUNTER_BITS, 32, width of period/duty counters
PULSE_BITS, 32, width of burst period counter
CH_BITS, 1, width of channel select (ceil(log2(NUM_CH)), min 1)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
cfg_we  in  1  one-cycle write strobe, loads config into channel cfg_ch
cfg_ch  in  CH_BITS  target channel; values >= NUM_CH ignored
cfg_mode  in  2  0 off, 1 free-run, 2 burst, 3 reserved (treated as off)
cfg_divider  in  COUNTER_BITS  period in clk cycles
cfg_high  in  COUNTER_BITS  high-phase length in clk cycles
cfg_pulse  in  PULSE_BITS  burst length in output periods
out_enable  in  1  global output enable; 0 forces clk_o/tick_o low
clk_o  out  NUM_CH  registered divided clock level per channel
tick_o  out  NUM_CH  one-cycle pulse at start of each output period
busy_o  out  NUM_CH  channel running (mode 1 or burst in progress)
done_o  out  NUM_CH  one-cycle pulse when a burst completes

Behaviour:
- Reset: all channels mode off, counters 0, clk_o=0, tick_o=0, busy_o=0, done_o=0.
- Effective period: div_eff = max(cfg_divider, 2). Effective high: high_eff = clamp(cfg_high, 1, div_eff-1); cfg_high=0 gives 50% duty, high_eff = div_eff/2 (floor). Both latched on write.
- Write (cfg_we=1, valid cfg_ch) always restarts the channel (phase reset), even mid-period or mid-burst. No done_o is generated for an aborted burst.
- Restart in mode 1/2: next cycle cnt=0, clk_o=1, tick_o=1, busy_o=1. Latency from cfg_we to first tick is 1 cycle.
- Running channel per clk: cnt_next = (cnt == div_eff-1) ? 0 : cnt+1. clk_o <= (cnt_next < high_eff). tick_o <= (cnt_next == 0).
- Burst: remaining loaded with cfg_pulse. Each period start, including the first, decrements remaining.
  - When remaining==0 and cnt wraps to 0, the channel stops: clk_o=0, tick_o=0, busy_o=0, done_o=1 for exactly that cycle. Mode returns to off.
  - cfg_pulse=0: no tick; busy_o stays 0; done_o pulses 1 cycle after the write.
- Mode 0 or 3 write: channel stops next cycle, clk_o=0, busy_o=0, no done_o.
- out_enable=0: clk_o and tick_o masked to 0. Counters, busy_o and done_o continue unaffected.
- Simultaneous reset and cfg_we: reset wins.
- Channels are fully independent; only one channel is writable per cycle.
- Counters wrap-safe: comparisons use the latched div_eff, never cnt > divider.

Optional Feature:
CLK_GEN_PHASE_SYNC_EN
- Defined: adds input sync_i (1 bit). When sync_i=1, every running channel sets cnt=0 next cycle, asserts tick_o, and counts a new burst period, aligning phases across channels. sync_i and cfg_we on the same channel in the same cycle: cfg_we wins.
- Undefined: port absent; channels are phase-aligned only by their own writes.

Test Plan:
- Reset, then write ch0 mode1 divider=4 high=0 -> clk_o[0] pattern 1,1,0,0 repeating from cycle after write; tick_o[0] every 4th cycle; busy_o[0]=1.
- ch1 mode2 divider=3 high=1 pulse=2 -> exactly 2 ticks, clk_o[1] = 1,0,0,1,0,0 then 0; done_o[1] high 1 cycle at 6 cycles after write's first output cycle; busy_o drops same cycle.
- divider=0 and divider=1 in mode1 -> both behave as divider=2 (clk_o toggles 1,0); cfg_high=7 with divider=4 clamps to high=3.
- Mid-burst rewrite of ch0 (pulse=5, rewrite after 2 ticks with mode0) -> clk_o[0]=0 next cycle, no done_o; burst with pulse=0 -> done_o 1 cycle after write, no tick.
- out_enable=0 for 3 cycles during mode1 divider=4 -> clk_o/tick_o forced 0; after re-enable the phase continues unshifted; busy_o stays 1; assert reset mid-run -> all outputs 0 next cycle.
- With CLK_GEN_PHASE_SYNC_EN: ch0 div=4, ch1 div=6 running offset; pulse sync_i -> both tick_o high next cycle together.

Source files
------------

// File: rtl/clk_gen_multi.sv
// clk_gen_multi: multi-channel programmable clock/tick generator with off, free-run and counted-burst modes
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-high reset
//   cfg_we       one-cycle write strobe; loads and restarts channel cfg_ch
//   cfg_ch       target channel (values >= NUM_CH are ignored)
//   cfg_mode     0 off, 1 free-run, 2 burst, 3 reserved (off)
//   cfg_divider  period in clk cycles (values below 2 act as 2)
//   cfg_high     high-phase length (0 selects 50% duty, clamped to 1..period-1)
//   cfg_pulse    burst length in output periods
//   out_enable   global enable; low forces clk_o/tick_o to 0 from the next cycle
//   sync_i       (CLK_GEN_PHASE_SYNC_EN only) restarts the period of every running channel
//   clk_o        registered divided clock level per channel
//   tick_o       one-cycle pulse at the start of each output period
//   busy_o       channel running
//   done_o       one-cycle pulse when a burst completes
//
// Build option: define CLK_GEN_PHASE_SYNC_EN to add the sync_i phase alignment input.
module clk_gen_multi #(
    parameter int NUM_CH       = 2,
    parameter int COUNTER_BITS = 32,
    parameter int PULSE_BITS   = 32,
    parameter int CH_BITS      = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cfg_we,
    input  logic [CH_BITS-1:0]      cfg_ch,
    input  logic [1:0]              cfg_mode,
    input  logic [COUNTER_BITS-1:0] cfg_divider,
    input  logic [COUNTER_BITS-1:0] cfg_high,
    input  logic [PULSE_BITS-1:0]   cfg_pulse,
    input  logic                    out_enable,
`ifdef CLK_GEN_PHASE_SYNC_EN
    input  logic                    sync_i,
`endif
    output logic [NUM_CH-1:0]       clk_o,
    output logic [NUM_CH-1:0]       tick_o,
    output logic [NUM_CH-1:0]       busy_o,
    output logic [NUM_CH-1:0]       done_o
);
    logic                    sync;
    logic [COUNTER_BITS-1:0] div_w;
    logic [COUNTER_BITS-1:0] high_w;
    logic                    go;
    logic                    bst_w;

`ifdef CLK_GEN_PHASE_SYNC_EN
    assign sync = sync_i;
`else
    assign sync = 1'b0;
`endif

    // Effective period and high phase are resolved once, at write time.
    always_comb begin
        div_w  = (cfg_divider < COUNTER_BITS'(2)) ? COUNTER_BITS'(2) : cfg_divider;
        high_w = (cfg_high == '0) ? (div_w >> 1)
               : (cfg_high > div_w - COUNTER_BITS'(1)) ? div_w - COUNTER_BITS'(1) : cfg_high;
    end

    // A zero-length burst never starts; it only reports completion.
    assign bst_w = cfg_mode == 2'd2;
    assign go    = cfg_mode == 2'd1 || (bst_w && cfg_pulse != '0);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic                    sel;
        logic                    run;
        logic                    burst;
        logic [COUNTER_BITS-1:0] cnt;
        logic [COUNTER_BITS-1:0] div;
        logic [COUNTER_BITS-1:0] high;
        logic [PULSE_BITS-1:0]   rem;
        logic                    lvl;
        logic                    tck;
        logic                    bsy;
        logic                    dn;
        logic                    wrap;
        logic                    stop;
        logic [COUNTER_BITS-1:0] cnt_n;

        assign sel = cfg_we && cfg_ch == CH_BITS'(i);

        // A sync request is treated exactly like a natural period wrap.
        always_comb begin
            wrap  = cnt == div - COUNTER_BITS'(1) || sync;
            stop  = run && burst && rem == '0 && wrap;
            cnt_n = wrap ? '0 : cnt + COUNTER_BITS'(1);
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                run   <= 1'b0;
                burst <= 1'b0;
                cnt   <= '0;
                div   <= '0;
                high  <= '0;
                rem   <= '0;
                lvl   <= 1'b0;
                tck   <= 1'b0;
                bsy   <= 1'b0;
                dn    <= 1'b0;
            end else if (sel) begin
                run   <= go;
                burst <= go && bst_w;
                cnt   <= '0;
                div   <= div_w;
                high  <= high_w;
                rem   <= cfg_pulse - PULSE_BITS'(1);
                lvl   <= go && out_enable;
                tck   <= go && out_enable;
                bsy   <= go;
                dn    <= bst_w && !go;
            end else if (run && !stop) begin
                cnt   <= cnt_n;
                rem   <= (burst && wrap) ? rem - PULSE_BITS'(1) : rem;
                lvl   <= (cnt_n < high) && out_enable;
                tck   <= wrap && out_enable;
                bsy   <= 1'b1;
                dn    <= 1'b0;
            end else begin
                run   <= 1'b0;
                burst <= 1'b0;
                lvl   <= 1'b0;
                tck   <= 1'b0;
                bsy   <= 1'b0;
                dn    <= stop;
            end
        end

        assign clk_o[i]  = lvl;
        assign tick_o[i] = tck;
        assign busy_o[i] = bsy;
        assign done_o[i] = dn;
    end
endmodule

// File: tb/tb_clk_gen_multi.sv
// tb_clk_gen_multi: scoreboard bench for clk_gen_multi (2 channels)
module tb_clk_gen_multi;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cfg_we = 1'b0;
    logic [0:0]  cfg_ch = '0;
    logic [1:0]  cfg_mode = '0;
    logic [31:0] cfg_divider = '0;
    logic [31:0] cfg_high = '0;
    logic [31:0] cfg_pulse = '0;
    logic        out_enable = 1'b1;
    logic [1:0]  clk_o;
    logic [1:0]  tick_o;
    logic [1:0]  busy_o;
    logic [1:0]  done_o;
`ifdef CLK_GEN_PHASE_SYNC_EN
    logic        sync_i = 1'b0;
`endif

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];
    string      tag_q[$];

    clk_gen_multi dut (
        .clk(clk),
        .reset(reset),
        .cfg_we(cfg_we),
        .cfg_ch(cfg_ch),
        .cfg_mode(cfg_mode),
        .cfg_divider(cfg_divider),
        .cfg_high(cfg_high),
        .cfg_pulse(cfg_pulse),
        .out_enable(out_enable),
`ifdef CLK_GEN_PHASE_SYNC_EN
        .sync_i(sync_i),
`endif
        .clk_o(clk_o),
        .tick_o(tick_o),
        .busy_o(busy_o),
        .done_o(done_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got clk/tick/busy/done=%b required=%b", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic [1:0] c, input logic [1:0] t,
                        input logic [1:0] b, input logic [1:0] d);
        exp_q.push_back({c, t, b, d});
        tag_q.push_back(tag);
    endtask

    // One clock: sample just after the edge and compare against the oldest expectation.
    task automatic run(input int n);
        for (int j = 0; j < n; j++) begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_empty got %0d entries required >0", exp_q.size());
            end else
                chk(tag_q.pop_front(), {clk_o, tick_o, busy_o, done_o}, exp_q.pop_front());
        end
    endtask

    task automatic wr(input logic ch, input logic [1:0] mode, input int dv, input int hi, input int pl);
        cfg_ch = ch;
        cfg_mode = mode;
        cfg_divider = dv;
        cfg_high = hi;
        cfg_pulse = pl;
        cfg_we = 1'b1;
        run(1);
        cfg_we = 1'b0;
    endtask

    // Free-running channel 0 pattern for phase k of a period dv with high phase hi.
    task automatic push_ch0(input string tag, input int k, input int dv, input int hi, input logic en);
        push(tag, {1'b0, en && (k % dv) < hi}, {1'b0, en && (k % dv) == 0}, 2'b01, 2'b00);
    endtask

    initial begin
        cfg_ch = 1'b0;
        cfg_mode = 2'd1;
        cfg_divider = 4;
        cfg_we = 1'b1;
        push("rst_we", 0, 0, 0, 0);
        push("rst_we", 0, 0, 0, 0);
        run(2);
        reset = 1'b0;
        cfg_we = 1'b0;
        push("rst_idle", 0, 0, 0, 0);
        run(1);

        for (int k = 0; k < 8; k++) push_ch0("free_div4", k, 4, 2, 1'b1);
        wr(0, 2'd1, 4, 0, 0);
        run(7);
        push("stop_mode0", 0, 0, 0, 0);
        push("stop_idle", 0, 0, 0, 0);
        wr(0, 2'd0, 4, 0, 0);
        run(1);

        for (int k = 0; k < 6; k++)
            push("burst2", {k % 3 == 0, 1'b0}, {k % 3 == 0, 1'b0}, 2'b10, 2'b00);
        push("burst_done", 0, 0, 0, 2'b10);
        push("burst_idle", 0, 0, 0, 0);
        wr(1, 2'd2, 3, 1, 2);
        run(7);

        for (int k = 0; k < 4; k++) push_ch0("div0", k, 2, 1, 1'b1);
        wr(0, 2'd1, 0, 0, 0);
        run(3);
        for (int k = 0; k < 4; k++) push_ch0("div1", k, 2, 1, 1'b1);
        wr(0, 2'd1, 1, 0, 0);
        run(3);
        for (int k = 0; k < 8; k++) push_ch0("high_clamp", k, 4, 3, 1'b1);
        wr(0, 2'd1, 4, 7, 0);
        run(7);

        for (int k = 0; k < 5; k++) push_ch0("burst5", k, 4, 2, 1'b1);
        for (int k = 0; k < 3; k++) push("abort", 0, 0, 0, 0);
        wr(0, 2'd2, 4, 0, 5);
        run(4);
        wr(0, 2'd0, 4, 0, 0);
        run(2);
        push("pulse0_done", 0, 0, 0, 2'b10);
        push("pulse0_idle", 0, 0, 0, 0);
        wr(1, 2'd2, 4, 0, 0);
        run(1);

        for (int k = 0; k < 10; k++) push_ch0("oe_mask", k, 4, 2, !(k >= 4 && k <= 6));
        wr(0, 2'd1, 4, 0, 0);
        run(3);
        out_enable = 1'b0;
        run(3);
        out_enable = 1'b1;
        run(3);
        push("reset_mid", 0, 0, 0, 0);
        push("reset_after", 0, 0, 0, 0);
        reset = 1'b1;
        run(1);
        reset = 1'b0;
        run(1);

`ifdef CLK_GEN_PHASE_SYNC_EN
        push("sync_a", 2'b01, 2'b01, 2'b01, 0);
        push("sync_b", 2'b01, 2'b00, 2'b01, 0);
        push("sync_c", 2'b10, 2'b10, 2'b11, 0);
        push("sync_d", 2'b10, 2'b00, 2'b11, 0);
        push("sync_e", 2'b11, 2'b11, 2'b11, 0);
        push("sync_f", 2'b11, 2'b00, 2'b11, 0);
        wr(0, 2'd1, 4, 0, 0);
        run(1);
        wr(1, 2'd1, 6, 0, 0);
        run(1);
        sync_i = 1'b1;
        run(1);
        sync_i = 1'b0;
        run(1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
